// File: rtl/alu_op_arbiter.sv
// alu_op_arbiter: two requesters share one 8-bit ALU.
// Define ALU_ARB_FIXED_PRIO_EN so requester 0 always wins ties.
module alu_op_arbiter #(
  parameter int LAT = 1,
  parameter int W   = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [2:0]   op0,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [2:0]   op1,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic [1:0]   gnt,
  output logic [1:0]   done,
  output logic [W-1:0] result,
  output logic         err,
  output logic         busy,
  output logic [2:0]   alu_in_sel,
  output logic [6:0]   alu_out_sel,
  output logic [W-1:0] alu_num1,
  output logic [W-1:0] alu_num2,
  input  logic [W-1:0] alu_result,
  input  logic         alu_ovf
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, WAIT, DONE
  } state_t;

  state_t       stateQ, stateN;
  logic [1:0]   gntQ, gntN;
  logic [2:0]   opQ, opN, opSel;
  logic [W-1:0] aQ, aN, bQ, bN;
  logic [W-1:0] resQ, resN;
  logic         errQ, errN;
  logic [3:0]   cntQ, cntN;
  logic [2:0]   inSelQ, inSelN;
  logic [6:0]   outSelQ, outSelN;
  logic         pick;
`ifndef ALU_ARB_FIXED_PRIO_EN
  logic         lastQ, lastN;
`endif

  // Winner select: 1 means requester 1.
`ifdef ALU_ARB_FIXED_PRIO_EN
  always_comb pick = ~req[0];
`else
  always_comb pick = (req == 2'b11) ? ~lastQ : req[1];
`endif

  // Next-state and datapath updates.
  always_comb begin
    stateN  = stateQ;
    gntN    = gntQ;
    opN     = opQ;
    aN      = aQ;
    bN      = bQ;
    resN    = resQ;
    errN    = errQ;
    cntN    = cntQ;
    outSelN = outSelQ;
`ifndef ALU_ARB_FIXED_PRIO_EN
    lastN   = lastQ;
`endif
    opSel   = pick ? op1 : op0;
    unique case (stateQ)
      IDLE: begin
        if (|req) begin
          gntN = pick ? 2'b10 : 2'b01;
          opN  = opSel;
          if (opSel == 3'd7) begin
            stateN = DONE;
            resN   = '0;
            errN   = 1'b1;
`ifndef ALU_ARB_FIXED_PRIO_EN
            lastN  = pick;
`endif
          end else begin
            stateN  = ISSUE;
            aN      = pick ? a1 : a0;
            bN      = pick ? b1 : b0;
            outSelN = 7'd1 << opSel;
          end
        end
      end
      ISSUE: begin
        stateN = WAIT;
        cntN   = 4'(LAT - 1);
      end
      WAIT: begin
        if (cntQ == 4'd0) begin
          stateN = DONE;
          resN   = alu_result;
          errN   = (opQ == 3'd6) && alu_ovf;
`ifndef ALU_ARB_FIXED_PRIO_EN
          lastN  = gntQ[1];
`endif
        end else begin
          cntN = cntQ - 4'd1;
        end
      end
      DONE: begin
        stateN = IDLE;
        gntN   = 2'b00;
      end
      default: stateN = IDLE;
    endcase
    inSelN = (stateN == ISSUE) ? 3'b010 : 3'b100;
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ  <= IDLE;
      gntQ    <= 2'b00;
      opQ     <= 3'd0;
      aQ      <= '0;
      bQ      <= '0;
      resQ    <= '0;
      errQ    <= 1'b0;
      cntQ    <= 4'd0;
      inSelQ  <= 3'b001;
      outSelQ <= 7'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      lastQ   <= 1'b1;
`endif
    end else begin
      stateQ  <= stateN;
      gntQ    <= gntN;
      opQ     <= opN;
      aQ      <= aN;
      bQ      <= bN;
      resQ    <= resN;
      errQ    <= errN;
      cntQ    <= cntN;
      inSelQ  <= inSelN;
      outSelQ <= outSelN;
`ifndef ALU_ARB_FIXED_PRIO_EN
      lastQ   <= lastN;
`endif
    end
  end

  assign gnt         = gntQ;
  assign done        = (stateQ == DONE) ? gntQ : 2'b00;
  assign result      = resQ;
  assign err         = errQ & (|gntQ);
  assign busy        = (stateQ != IDLE);
  assign alu_in_sel  = inSelQ;
  assign alu_out_sel = outSelQ;
  assign alu_num1    = aQ;
  assign alu_num2    = bQ;

endmodule

// File: tb/tb_alu_op_arbiter.sv
// tb_alu_op_arbiter: scoreboard bench for alu_op_arbiter.
// Runs a LAT=1 instance and a LAT=4 instance.
module tb_alu_op_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] req, gnt, done;
  logic [2:0] op0, op1, inSel;
  logic [7:0] a0, b0, a1, b1;
  logic [7:0] result, num1, num2, aluRes;
  logic       err, busy, aluOvf;
  logic [6:0] outSel;

  logic [1:0] req4, gnt4, done4;
  logic [2:0] op04, inSel4;
  logic [7:0] a04, b04;
  logic [7:0] result4, num14, num24, aluRes4;
  logic       err4, busy4, aluOvf4;
  logic [6:0] outSel4;

  alu_op_arbiter #(.LAT(1), .W(8)) dut (
    .clk(clk), .rst(rst), .req(req),
    .op0(op0), .a0(a0), .b0(b0),
    .op1(op1), .a1(a1), .b1(b1),
    .gnt(gnt), .done(done),
    .result(result), .err(err), .busy(busy),
    .alu_in_sel(inSel), .alu_out_sel(outSel),
    .alu_num1(num1), .alu_num2(num2),
    .alu_result(aluRes), .alu_ovf(aluOvf)
  );

  alu_op_arbiter #(.LAT(4), .W(8)) dut4 (
    .clk(clk), .rst(rst), .req(req4),
    .op0(op04), .a0(a04), .b0(b04),
    .op1(3'd0), .a1(8'd0), .b1(8'd0),
    .gnt(gnt4), .done(done4),
    .result(result4), .err(err4), .busy(busy4),
    .alu_in_sel(inSel4), .alu_out_sel(outSel4),
    .alu_num1(num14), .alu_num2(num24),
    .alu_result(aluRes4), .alu_ovf(aluOvf4)
  );

  // ALU models: load operands on 010, compute from one-hot op.
  logic [7:0]  mA, mB, mA4, mB4;
  logic [15:0] prod, prod4;

  always_ff @(posedge clk)
    if (inSel == 3'b010) begin
      mA <= num1;
      mB <= num2;
    end

  always_ff @(posedge clk)
    if (inSel4 == 3'b010) begin
      mA4 <= num14;
      mB4 <= num24;
    end

  always_comb begin
    prod   = 16'(mA) * 16'(mB);
    aluOvf = |prod[15:8];
    case (outSel)
      7'b0000001: aluRes = mA & mB;
      7'b0000010: aluRes = mA | mB;
      7'b0000100: aluRes = ~mA;
      7'b0001000: aluRes = mA ^ mB;
      7'b0010000: aluRes = mA + mB;
      7'b0100000: aluRes = mA - mB;
      7'b1000000: aluRes = prod[7:0];
      default:    aluRes = 8'h00;
    endcase
  end

  always_comb begin
    prod4   = 16'(mA4) * 16'(mB4);
    aluOvf4 = |prod4[15:8];
    case (outSel4)
      7'b0000001: aluRes4 = mA4 & mB4;
      7'b0000010: aluRes4 = mA4 | mB4;
      7'b0000100: aluRes4 = ~mA4;
      7'b0001000: aluRes4 = mA4 ^ mB4;
      7'b0010000: aluRes4 = mA4 + mB4;
      7'b0100000: aluRes4 = mA4 - mB4;
      7'b1000000: aluRes4 = prod4[7:0];
      default:    aluRes4 = 8'h00;
    endcase
  end

  typedef struct {
    logic [1:0] who;
    logic [7:0] res;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   lastTb = 1'b1;

  task automatic test_reset();
    rst = 1'b0;
    req = 2'b00; req4 = 2'b00;
    op0 = 3'd0; a0 = 8'd0; b0 = 8'd0;
    op1 = 3'd0; a1 = 8'd0; b1 = 8'd0;
    op04 = 3'd0; a04 = 8'd0; b04 = 8'd0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, done, result, err, busy} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outs got %h exp 0",
               {gnt, done, result, err, busy});
    end
    checks++;
    if (inSel !== 3'b001) begin
      errors++;
      $display("FAIL reset_insel got %b exp 001", inSel);
    end
    checks++;
    if ({outSel, num1, num2} !== 23'd0) begin
      errors++;
      $display("FAIL reset_alu got %h exp 0",
               {outSel, num1, num2});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (inSel !== 3'b100 || busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_persist got %b/%b exp 100/0",
               inSel, busy);
    end
  endtask

  task automatic test_add();
    int   n;
    exp_t x;
    op0 = 3'd4; a0 = 8'd100; b0 = 8'd27;
    req = 2'b01;
    sb.push_back('{2'b01, 8'd127, 1'b0});
    @(negedge clk);
    n = 1;
    checks++;
    if (gnt !== 2'b01) begin
      errors++;
      $display("FAIL add_gnt got %b exp 01", gnt);
    end
    checks++;
    if (inSel !== 3'b010) begin
      errors++;
      $display("FAIL add_load got %b exp 010", inSel);
    end
    checks++;
    if ({num1, num2, outSel} !== {8'd100, 8'd27, 7'h10}) begin
      errors++;
      $display("FAIL add_issue got %h/%h/%b exp 64/1b/0010000",
               num1, num2, outSel);
    end
    while (done === 2'b00 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL add_latency got %0d exp 3", n);
    end
    x = sb.pop_front();
    checks++;
    if ({done, result, err} !== {x.who, x.res, x.e}) begin
      errors++;
      $display("FAIL add_done got %b/%h/%b exp %b/%h/%b",
               done, result, err, x.who, x.res, x.e);
    end
    req = 2'b00;
    lastTb = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, gnt, busy} !== 5'd0 || result !== 8'd127) begin
      errors++;
      $display("FAIL add_after got %b/%b/%b/%h exp 00/00/0/7f",
               done, gnt, busy, result);
    end
  endtask

  task automatic test_mult();
    int   n;
    exp_t x;
    op1 = 3'd6; a1 = 8'd20; b1 = 8'd20;
    req = 2'b10;
    sb.push_back('{2'b10, 8'd144, 1'b1});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done === 2'b00 && n < 20);
    x = sb.pop_front();
    checks++;
    if ({done, result, err} !== {x.who, x.res, x.e}) begin
      errors++;
      $display("FAIL mult_done got %b/%h/%b exp %b/%h/%b",
               done, result, err, x.who, x.res, x.e);
    end
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL mult_latency got %0d exp 3", n);
    end
    req = 2'b00;
    lastTb = 1'b1;
    @(negedge clk);
    checks++;
    if (err !== 1'b0 || gnt !== 2'b00) begin
      errors++;
      $display("FAIL mult_err_nognt got %b/%b exp 0/00", err, gnt);
    end
  endtask

  task automatic test_contention();
    int   n;
    bit   win;
    exp_t x;
    op0 = 3'd4; a0 = 8'd1;  b0 = 8'd2;
    op1 = 3'd5; a1 = 8'd10; b1 = 8'd3;
    req = 2'b11;
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = ~lastTb;
`endif
      if (win) sb.push_back('{2'b10, 8'd7, 1'b0});
      else     sb.push_back('{2'b01, 8'd3, 1'b0});
      lastTb = win;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (done === 2'b00 && n < 20);
      x = sb.pop_front();
      checks++;
      if ({done, result, err} !== {x.who, x.res, x.e}) begin
        errors++;
        $display("FAIL cont_%0d got %b/%h/%b exp %b/%h/%b", i,
                 done, result, err, x.who, x.res, x.e);
      end
      checks++;
      if (n !== ((i == 0) ? 3 : 4)) begin
        errors++;
        $display("FAIL cont_gap_%0d got %0d exp %0d", i, n,
                 (i == 0) ? 3 : 4);
      end
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_illegal();
    int   n;
    bit   loaded;
    exp_t x;
    op0 = 3'd7; a0 = 8'h55; b0 = 8'hAA;
    req = 2'b01;
    sb.push_back('{2'b01, 8'd0, 1'b1});
    n = 0;
    loaded = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (inSel === 3'b010) loaded = 1'b1;
    end while (done === 2'b00 && n < 20);
    x = sb.pop_front();
    checks++;
    if ({done, result, err} !== {x.who, x.res, x.e}) begin
      errors++;
      $display("FAIL illegal_done got %b/%h/%b exp %b/%h/%b",
               done, result, err, x.who, x.res, x.e);
    end
    checks++;
    if (n !== 1 || loaded !== 1'b0) begin
      errors++;
      $display("FAIL illegal_path got n=%0d load=%b exp 1/0",
               n, loaded);
    end
    req = 2'b00;
    lastTb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_wait();
    int   n;
    bit   sawDone;
    exp_t x;
    op0 = 3'd4; a0 = 8'd1; b0 = 8'd1;
    req = 2'b01;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1 || gnt !== 2'b01 || inSel !== 3'b100) begin
      errors++;
      $display("FAIL rw_inwait got %b/%b/%b exp 1/01/100",
               busy, gnt, inSel);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if ({gnt, done, result, err, busy} !== 14'd0 ||
        inSel !== 3'b001 || {outSel, num1, num2} !== 23'd0) begin
      errors++;
      $display("FAIL rw_async got %b/%b/%h/%b/%b/%b exp reset",
               gnt, done, result, err, busy, inSel);
    end
    req = 2'b00;
    sawDone = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 2'b00) sawDone = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    if (done !== 2'b00) sawDone = 1'b1;
    checks++;
    if (sawDone !== 1'b0) begin
      errors++;
      $display("FAIL rw_nodone got 1 exp 0");
    end
    lastTb = 1'b1;
    op0 = 3'd0; a0 = 8'hF0; b0 = 8'h3C;
    req = 2'b01;
    sb.push_back('{2'b01, 8'h30, 1'b0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done === 2'b00 && n < 20);
    x = sb.pop_front();
    checks++;
    if ({done, result, err} !== {x.who, x.res, x.e} || n !== 3) begin
      errors++;
      $display("FAIL rw_and got %b/%h/%b n=%0d exp %b/%h/%b n=3",
               done, result, err, n, x.who, x.res, x.e);
    end
    req = 2'b00;
    lastTb = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lat4();
    int   n;
    exp_t x;
    op04 = 3'd5; a04 = 8'd5; b04 = 8'd9;
    req4 = 2'b01;
    sb.push_back('{2'b01, 8'hFC, 1'b0});
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        checks++;
        if (gnt4 !== 2'b01) begin
          errors++;
          $display("FAIL lat4_gnt got %b exp 01", gnt4);
        end
      end
    end while (done4 === 2'b00 && n < 30);
    x = sb.pop_front();
    checks++;
    if ({done4, result4, err4} !== {x.who, x.res, x.e}) begin
      errors++;
      $display("FAIL lat4_done got %b/%h/%b exp %b/%h/%b",
               done4, result4, err4, x.who, x.res, x.e);
    end
    checks++;
    if (n !== 6) begin
      errors++;
      $display("FAIL lat4_latency got %0d exp 6", n);
    end
    req4 = 2'b00;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mult();
    test_contention();
    test_illegal();
    test_reset_wait();
    test_lat4();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
